// File: rtl/prf_writeback_arbiter_pkg.sv
// Shared types and widths for the PRF writeback arbiter and its per-source result FIFOs.
package prf_writeback_arbiter_pkg;

  localparam int PREG_W   = 7;
  localparam int DATA_W   = 32;
  localparam int NUM_FU   = 3;
  localparam int SRC_ID_W = 2;

  typedef struct packed {
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/prf_writeback_arbiter_if.sv
// Bundle of FU result inputs and PRF write-port / wakeup outputs.
interface prf_writeback_arbiter_if
  import prf_writeback_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_FU,
  parameter int NUM_WP  = 2
) ();

  logic [NUM_SRC-1:0]                 src_valid;
  logic [NUM_SRC-1:0]                 src_ready;
  logic [NUM_SRC-1:0][PREG_W-1:0]     src_preg;
  logic [NUM_SRC-1:0][DATA_W-1:0]     src_data;
  logic [NUM_WP-1:0]                  wp_en;
  logic [NUM_WP-1:0][PREG_W-1:0]      wp_preg;
  logic [NUM_WP-1:0][DATA_W-1:0]      wp_data;
  logic [NUM_WP-1:0][SRC_ID_W-1:0]    wp_src;

  modport master (
    output src_valid, src_preg, src_data,
    input  src_ready, wp_en, wp_preg, wp_data, wp_src
  );

  modport slave (
    input  src_valid, src_preg, src_data,
    output src_ready, wp_en, wp_preg, wp_data, wp_src
  );

endinterface

// File: rtl/prf_writeback_arbiter_wb_src_fifo.sv
// Small per-source result FIFO with registered occupancy count and wrap-around pointers.
module wb_src_fifo
  import prf_writeback_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  input  logic    flush,
  output wb_req_t head,
  output logic    empty,
  output logic    full
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  wb_req_t          mem_q [BUF_DEPTH];
  wb_req_t          mem_d [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(BUF_DEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/prf_writeback_arbiter.sv
// Round-robin arbiter sharing NUM_WP PRF write ports among NUM_SRC buffered FU results.
module prf_writeback_arbiter
  import prf_writeback_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = NUM_FU,
  parameter int NUM_WP    = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mispredict,
  prf_writeback_arbiter_if.slave  wb
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] fifo_push;
  logic [NUM_SRC-1:0] fifo_pop;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] fifo_full;
  wb_req_t            fifo_head [NUM_SRC];

  logic [SRC_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [NUM_WP-1:0]                wp_en_q, wp_en_d;
  logic [NUM_WP-1:0][PREG_W-1:0]    wp_preg_q, wp_preg_d;
  logic [NUM_WP-1:0][DATA_W-1:0]    wp_data_q, wp_data_d;
  logic [NUM_WP-1:0][SRC_ID_W-1:0]  wp_src_q, wp_src_d;

  logic [SRC_W:0]   scan_idx;
  logic [SRC_W-1:0] src_sel;
  logic [SRC_W-1:0] last_src;
  logic             any_grant;
  int               grant_cnt;

  // Writes to preg 0 are swallowed here so they never reach the PRF.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    assign fifo_push[s] = wb.src_valid[s] && wb.src_ready[s] && !mispredict &&
                          (wb.src_preg[s] != '0);

    wb_src_fifo #(
      .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push[s]),
      .push_data ('{preg: wb.src_preg[s], data: wb.src_data[s]}),
      .pop       (fifo_pop[s]),
      .flush     (mispredict),
      .head      (fifo_head[s]),
      .empty     (fifo_empty[s]),
      .full      (fifo_full[s])
    );
  end

  assign wb.src_ready = ~fifo_full & {NUM_SRC{~reset}};
  assign wb.wp_en     = wp_en_q;
  assign wb.wp_preg   = wp_preg_q;
  assign wb.wp_data   = wp_data_q;
  assign wb.wp_src    = wp_src_q;

  // Scan from rr_ptr with wrap; the k-th non-empty head found takes port k.
  always_comb begin
    wp_en_d   = '0;
    wp_preg_d = wp_preg_q;
    wp_data_d = wp_data_q;
    wp_src_d  = wp_src_q;
    fifo_pop  = '0;
    rr_ptr_d  = rr_ptr_q;
    scan_idx  = '0;
    src_sel   = '0;
    last_src  = '0;
    any_grant = 1'b0;
    grant_cnt = 0;
    if (!mispredict) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        scan_idx = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
        if (scan_idx >= (SRC_W+1)'(NUM_SRC)) begin
          scan_idx = scan_idx - (SRC_W+1)'(NUM_SRC);
        end
        src_sel = scan_idx[SRC_W-1:0];
        if (!fifo_empty[src_sel] && (grant_cnt < NUM_WP)) begin
          for (int p = 0; p < NUM_WP; p++) begin
            if (p == grant_cnt) begin
              wp_en_d[p]   = 1'b1;
              wp_preg_d[p] = fifo_head[src_sel].preg;
              wp_data_d[p] = fifo_head[src_sel].data;
              wp_src_d[p]  = SRC_ID_W'(src_sel);
            end
          end
          fifo_pop[src_sel] = 1'b1;
          last_src          = src_sel;
          any_grant         = 1'b1;
          grant_cnt         = grant_cnt + 1;
        end
      end
      if (any_grant) begin
        rr_ptr_d = (last_src == SRC_W'(NUM_SRC - 1)) ? '0 : last_src + SRC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      wp_en_q   <= '0;
      wp_preg_q <= '0;
      wp_data_q <= '0;
      wp_src_q  <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wp_en_q   <= wp_en_d;
      wp_preg_q <= wp_preg_d;
      wp_data_q <= wp_data_d;
      wp_src_q  <= wp_src_d;
    end
  end

endmodule

// File: tb/tb_prf_writeback_arbiter.sv
// Randomized bench for prf_writeback_arbiter against a queue-based reference model.
module tb_prf_writeback_arbiter;
  import prf_writeback_arbiter_pkg::*;

  localparam int NUM_SRC   = 3;
  localparam int NUM_WP    = 2;
  localparam int BUF_DEPTH = 2;

  typedef struct {
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic mispredict;

  always #5 clk = ~clk;

  prf_writeback_arbiter_if #(.NUM_SRC(NUM_SRC), .NUM_WP(NUM_WP)) wb_if ();

  prf_writeback_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .NUM_WP    (NUM_WP),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mispredict (mispredict),
    .wb         (wb_if)
  );

  ent_t              model_q [NUM_SRC][$];
  int                rr_model;
  logic [NUM_WP-1:0] exp_en;
  logic [PREG_W-1:0] exp_preg [NUM_WP];
  logic [DATA_W-1:0] exp_data [NUM_WP];
  logic [1:0]        exp_src  [NUM_WP];

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < NUM_SRC; s++) model_q[s].delete();
    rr_model = 0;
    exp_en   = '0;
    for (int p = 0; p < NUM_WP; p++) begin
      exp_preg[p] = '0;
      exp_data[p] = '0;
      exp_src[p]  = '0;
    end
  endtask

  // Effect of one rising edge on the model, given the inputs presented before it.
  task automatic modelEdge(input logic [NUM_SRC-1:0] v,
                           input logic [NUM_SRC-1:0][PREG_W-1:0] pr,
                           input logic [NUM_SRC-1:0][DATA_W-1:0] dt,
                           input logic mp);
    bit   rdy [NUM_SRC];
    int   granted;
    int   last;
    int   s;
    ent_t e;
    for (int k = 0; k < NUM_SRC; k++) rdy[k] = (model_q[k].size() < BUF_DEPTH);
    exp_en = '0;
    if (mp) begin
      for (int k = 0; k < NUM_SRC; k++) model_q[k].delete();
      return;
    end
    granted = 0;
    last    = -1;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = (rr_model + i) % NUM_SRC;
      if (granted < NUM_WP && model_q[s].size() > 0) begin
        e = model_q[s].pop_front();
        exp_en[granted]   = 1'b1;
        exp_preg[granted] = e.preg;
        exp_data[granted] = e.data;
        exp_src[granted]  = 2'(s);
        granted++;
        last = s;
      end
    end
    if (last >= 0) rr_model = (last + 1) % NUM_SRC;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (v[k] && rdy[k] && pr[k] != '0) begin
        e.preg = pr[k];
        e.data = dt[k];
        model_q[k].push_back(e);
      end
    end
  endtask

  task automatic compareWp();
    checkOutput("wp_en", 64'(wb_if.wp_en), 64'(exp_en));
    for (int p = 0; p < NUM_WP; p++) begin
      checkOutput($sformatf("wp_preg[%0d]", p), 64'(wb_if.wp_preg[p]), 64'(exp_preg[p]));
      checkOutput($sformatf("wp_data[%0d]", p), 64'(wb_if.wp_data[p]), 64'(exp_data[p]));
      checkOutput($sformatf("wp_src[%0d]", p),  64'(wb_if.wp_src[p]),  64'(exp_src[p]));
    end
  endtask

  // Entered at a falling edge; leaves at the next falling edge after checking outputs.
  task automatic doCycle(input logic [NUM_SRC-1:0] v,
                         input logic [NUM_SRC-1:0][PREG_W-1:0] pr,
                         input logic [NUM_SRC-1:0][DATA_W-1:0] dt,
                         input logic mp);
    wb_if.src_valid = v;
    wb_if.src_preg  = pr;
    wb_if.src_data  = dt;
    mispredict      = mp;
    #1;
    for (int s = 0; s < NUM_SRC; s++) begin
      checkOutput($sformatf("src_ready[%0d]", s), 64'(wb_if.src_ready[s]),
                  64'(model_q[s].size() < BUF_DEPTH));
    end
    modelEdge(v, pr, dt, mp);
    @(negedge clk);
    compareWp();
  endtask

  task automatic doReset();
    reset           = 1'b1;
    wb_if.src_valid = '0;
    mispredict      = 1'b0;
    modelReset();
    #1;
    checkOutput("ready_in_reset", 64'(wb_if.src_ready), 64'(0));
    compareWp();
    @(negedge clk);
    compareWp();
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", 64'(wb_if.src_ready), 64'(3'b111));
  endtask

  task automatic applyStimulus(input int n, input int valid_pct, input int zero_pct, input int mp_pct);
    logic [NUM_SRC-1:0]             v;
    logic [NUM_SRC-1:0][PREG_W-1:0] pr;
    logic [NUM_SRC-1:0][DATA_W-1:0] dt;
    logic                           mp;
    for (int c = 0; c < n; c++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        v[s]  = ($urandom_range(0, 99) < valid_pct);
        pr[s] = ($urandom_range(0, 99) < zero_pct) ? '0 : PREG_W'($urandom_range(1, 127));
        dt[s] = $urandom;
      end
      mp = ($urandom_range(0, 99) < mp_pct);
      doCycle(v, pr, dt, mp);
    end
  endtask

  logic [NUM_SRC-1:0][PREG_W-1:0] pr_t;
  logic [NUM_SRC-1:0][DATA_W-1:0] dt_t;

  initial begin
    reset           = 1'b1;
    mispredict      = 1'b0;
    wb_if.src_valid = '0;
    wb_if.src_preg  = '0;
    wb_if.src_data  = '0;
    @(negedge clk);
    doReset();

    // Lone ALU result shows up on port 0 one cycle after acceptance, for one cycle.
    pr_t = '0; dt_t = '0;
    pr_t[0] = 7'd5; dt_t[0] = 32'hDEAD_BEEF;
    doCycle(3'b001, pr_t, dt_t, 1'b0);
    checkOutput("t2_no_early_wp", 64'(wb_if.wp_en), 64'(0));
    doCycle(3'b000, pr_t, dt_t, 1'b0);
    checkOutput("t2_wp_en", 64'(wb_if.wp_en), 64'(2'b01));
    checkOutput("t2_wp_preg0", 64'(wb_if.wp_preg[0]), 64'(5));
    checkOutput("t2_wp_data0", 64'(wb_if.wp_data[0]), 64'(32'hDEAD_BEEF));
    doCycle(3'b000, pr_t, dt_t, 1'b0);
    checkOutput("t2_one_cycle", 64'(wb_if.wp_en), 64'(0));

    // All sources busy every cycle: rotation {0,1},{2,0},{1,2}.
    doReset();
    for (int c = 0; c < 5; c++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        pr_t[s] = PREG_W'(1 + c * NUM_SRC + s);
        dt_t[s] = $urandom;
      end
      doCycle(3'b111, pr_t, dt_t, 1'b0);
      if (c == 1) begin
        checkOutput("t3_c1_src0", 64'(wb_if.wp_src[0]), 64'(0));
        checkOutput("t3_c1_src1", 64'(wb_if.wp_src[1]), 64'(1));
      end else if (c == 2) begin
        checkOutput("t3_c2_src0", 64'(wb_if.wp_src[0]), 64'(2));
        checkOutput("t3_c2_src1", 64'(wb_if.wp_src[1]), 64'(0));
      end else if (c == 3) begin
        checkOutput("t3_c3_src0", 64'(wb_if.wp_src[0]), 64'(1));
        checkOutput("t3_c3_src1", 64'(wb_if.wp_src[1]), 64'(2));
      end
    end

    // Mispredict with results buffered: nothing issues, inputs lost, rr_ptr kept at 2.
    doCycle(3'b111, pr_t, dt_t, 1'b1);
    checkOutput("t6_wp_en_flush", 64'(wb_if.wp_en), 64'(0));
    doCycle(3'b000, pr_t, dt_t, 1'b0);
    checkOutput("t6_empty_after", 64'(wb_if.wp_en), 64'(0));
    doCycle(3'b111, pr_t, dt_t, 1'b0);
    doCycle(3'b000, pr_t, dt_t, 1'b0);
    checkOutput("t6_rr_src0", 64'(wb_if.wp_src[0]), 64'(2));
    checkOutput("t6_rr_src1", 64'(wb_if.wp_src[1]), 64'(0));

    // preg 0 from the LSU is accepted and silently dropped.
    doReset();
    pr_t = '0; dt_t = '0; dt_t[2] = 32'h1234_5678;
    doCycle(3'b100, pr_t, dt_t, 1'b0);
    doCycle(3'b000, pr_t, dt_t, 1'b0);
    checkOutput("t5_nothing", 64'(wb_if.wp_en), 64'(0));
    checkOutput("t5_ready", 64'(wb_if.src_ready), 64'(3'b111));

    // Random traffic, then a reset with FIFOs loaded, then more traffic.
    applyStimulus(800, 70, 10, 3);
    applyStimulus(6, 100, 0, 0);
    doReset();
    doCycle(3'b000, pr_t, dt_t, 1'b0);
    checkOutput("t1_empty_after_reset", 64'(wb_if.wp_en), 64'(0));
    applyStimulus(800, 85, 5, 2);
    applyStimulus(300, 30, 20, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
